// File: rtl/sys_array_tile_sched_pkg.sv
// ----------------------------------------------------------------------------
// sys_array_pkg
// Types and helpers shared by the tile scheduler, its job accounting
// sub-module and the scheduler bus interface.
//   node_idx_t     16-bit index into the split-node table
//   sched_state_e  scheduler FSM state encoding
//   sat_inc16      16-bit increment that sticks at 16'hFFFF
// ----------------------------------------------------------------------------
package sys_array_pkg;

    typedef logic [15:0] node_idx_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_CHECK  = 3'd2,
        S_ISSUE  = 3'd3,
        S_DRAIN  = 3'd4,
        S_FINISH = 3'd5
    } sched_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sys_array_tile_sched_if.sv
// ----------------------------------------------------------------------------
// sys_array_tile_sched_if
// Bus between the tile scheduler, the node table and the array controller.
//   rd_addr / rd_*      node-table read port (data one cycle after address)
//   job_valid/job_ready tile-job handshake, job_* payload
//   tile_done           completion pulse from the array controller
// Modports: master = scheduler side, slave = table/array side.
// ----------------------------------------------------------------------------
interface sys_array_tile_sched_if;
    import sys_array_pkg::*;

    node_idx_t   rd_addr;
    logic [15:0] rd_to_n1;
    logic [15:0] rd_a_w0;
    logic [15:0] rd_a_w1;
    logic [15:0] rd_a_l0;
    logic [15:0] rd_a_l1;
    logic [15:0] rd_b_l0;
    logic [15:0] rd_b_l1;

    logic        job_valid;
    logic        job_ready;
    node_idx_t   job_node;
    logic [15:0] job_a_w0;
    logic [15:0] job_a_w1;
    logic [15:0] job_a_l0;
    logic [15:0] job_a_l1;
    logic [15:0] job_b_l0;
    logic [15:0] job_b_l1;

    logic        tile_done;

    modport master (
        output rd_addr,
        input  rd_to_n1, rd_a_w0, rd_a_w1, rd_a_l0, rd_a_l1, rd_b_l0, rd_b_l1,
        output job_valid, job_node,
        output job_a_w0, job_a_w1, job_a_l0, job_a_l1, job_b_l0, job_b_l1,
        input  job_ready, tile_done
    );

    modport slave (
        input  rd_addr,
        output rd_to_n1, rd_a_w0, rd_a_w1, rd_a_l0, rd_a_l1, rd_b_l0, rd_b_l1,
        input  job_valid, job_node,
        input  job_a_w0, job_a_w1, job_a_l0, job_a_l1, job_b_l0, job_b_l1,
        output job_ready, tile_done
    );

endinterface

// File: rtl/sys_array_tile_sched_job_cnt.sv
// ----------------------------------------------------------------------------
// sys_array_job_cnt
// Tracks tile jobs in flight and per-pass issue/complete counters.
//   clk, reset_n     clock, async active-low reset
//   clr              start of a new pass: zero everything
//   accept           a job handshake completed this cycle
//   tile_done        one in-flight job finished this cycle
//   can_issue        in-flight count is below MAX_OUTSTANDING
//   none_out         nothing in flight
//   underflow        tile_done with nothing in flight (ignored otherwise)
//   jobs_issued/jobs_completed  saturating 16-bit counters
// ----------------------------------------------------------------------------
module sys_array_job_cnt
    import sys_array_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clr,
    input  logic        accept,
    input  logic        tile_done,
    output logic        can_issue,
    output logic        none_out,
    output logic        underflow,
    output logic [15:0] jobs_issued,
    output logic [15:0] jobs_completed
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0] MAX_W = OW'(MAX_OUTSTANDING);

    logic [OW-1:0] outstanding;

    assign can_issue = (outstanding < MAX_W);
    assign none_out  = (outstanding == '0);
    // A completion arriving with an acceptance in the same cycle is legal
    // even at zero in flight: the accepted job is the one being retired.
    assign underflow = tile_done & ~accept & none_out & ~clr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outstanding    <= '0;
            jobs_issued    <= '0;
            jobs_completed <= '0;
        end else if (clr) begin
            outstanding    <= '0;
            jobs_issued    <= '0;
            jobs_completed <= '0;
        end else begin
            if (accept && !tile_done) begin
                outstanding <= outstanding + 1'b1;
            end else if (tile_done && !accept && !none_out) begin
                outstanding <= outstanding - 1'b1;
            end
            if (accept) begin
                jobs_issued <= sat_inc16(jobs_issued);
            end
            if (tile_done && !underflow) begin
                jobs_completed <= sat_inc16(jobs_completed);
            end
        end
    end

endmodule

// File: rtl/sys_array_tile_sched.sv
// ----------------------------------------------------------------------------
// sys_array_tile_sched
// Walks the split-node table from node 0 to node_last, offering every leaf
// node as a tile job to the array controller while keeping at most
// MAX_OUTSTANDING jobs in flight, then waits for all of them to complete.
//
//   state  | meaning
//   IDLE   | no pass running; done holds the last result
//   FETCH  | rd_addr = idx, table read in progress
//   CHECK  | table data valid; leaf -> latch job, else skip node
//   ISSUE  | offer job (job_valid) while in-flight limit allows
//   DRAIN  | all nodes visited, waiting for in-flight jobs to finish
//   FINISH | raise done, drop busy
//
// Ports: clk, reset_n (async active-low), start, node_last, bus (master
// modport of sys_array_tile_sched_if), busy, done, err (sticky),
// jobs_issued, jobs_completed.
// ----------------------------------------------------------------------------
module sys_array_tile_sched
    import sys_array_pkg::*;
#(
    parameter int OUT_SIZE        = 100,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  node_idx_t                     node_last,
    sys_array_tile_sched_if.master        bus,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [15:0]                   jobs_issued,
    output logic [15:0]                   jobs_completed
);

    localparam logic [2:0] ST_IDLE   = S_IDLE;
    localparam logic [2:0] ST_FETCH  = S_FETCH;
    localparam logic [2:0] ST_CHECK  = S_CHECK;
    localparam logic [2:0] ST_ISSUE  = S_ISSUE;
    localparam logic [2:0] ST_DRAIN  = S_DRAIN;
    localparam logic [2:0] ST_FINISH = S_FINISH;

    localparam logic [31:0] OUT_SIZE_W = 32'(OUT_SIZE);

    logic [2:0]  state;
    node_idx_t   idx;
    node_idx_t   node_last_q;
    node_idx_t   job_node_q;
    logic [15:0] a_w0_q, a_w1_q, a_l0_q, a_l1_q, b_l0_q, b_l1_q;

    logic accept;
    logic can_issue;
    logic none_out;
    logic underflow;
    logic at_last;
    logic bad_last;

    sys_array_job_cnt #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_job_cnt (
        .clk            (clk),
        .reset_n        (reset_n),
        .clr            (start),
        .accept         (accept),
        .tile_done      (bus.tile_done),
        .can_issue      (can_issue),
        .none_out       (none_out),
        .underflow      (underflow),
        .jobs_issued    (jobs_issued),
        .jobs_completed (jobs_completed)
    );

    // idx is held steady through FETCH, so the synchronous table read
    // launched by rd_addr returns its data in CHECK.
    assign bus.rd_addr   = idx;
    assign bus.job_valid = (state == ST_ISSUE) && can_issue;
    assign bus.job_node  = job_node_q;
    assign bus.job_a_w0  = a_w0_q;
    assign bus.job_a_w1  = a_w1_q;
    assign bus.job_a_l0  = a_l0_q;
    assign bus.job_a_l1  = a_l1_q;
    assign bus.job_b_l0  = b_l0_q;
    assign bus.job_b_l1  = b_l1_q;

    assign accept   = bus.job_valid & bus.job_ready;
    assign at_last  = (idx == node_last_q);
    assign bad_last = ({16'h0000, node_last} >= OUT_SIZE_W);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            idx         <= '0;
            node_last_q <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            job_node_q  <= '0;
            a_w0_q      <= '0;
            a_w1_q      <= '0;
            a_l0_q      <= '0;
            a_l1_q      <= '0;
            b_l0_q      <= '0;
            b_l1_q      <= '0;
        end else if (start) begin
            idx         <= '0;
            node_last_q <= node_last;
            busy        <= 1'b1;
            done        <= 1'b0;
            err         <= bad_last;
            state       <= bad_last ? ST_FINISH : ST_FETCH;
        end else begin
            if (underflow) begin
                err <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    state <= ST_IDLE;
                end
                ST_FETCH: begin
                    state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (bus.rd_to_n1 == 16'd0) begin
                        job_node_q <= idx;
                        a_w0_q     <= bus.rd_a_w0;
                        a_w1_q     <= bus.rd_a_w1;
                        a_l0_q     <= bus.rd_a_l0;
                        a_l1_q     <= bus.rd_a_l1;
                        b_l0_q     <= bus.rd_b_l0;
                        b_l1_q     <= bus.rd_b_l1;
                        state      <= ST_ISSUE;
                    end else if (at_last) begin
                        state <= ST_DRAIN;
                    end else begin
                        idx   <= idx + 16'd1;
                        state <= ST_FETCH;
                    end
                end
                ST_ISSUE: begin
                    if (accept) begin
                        if (at_last) begin
                            state <= ST_DRAIN;
                        end else begin
                            idx   <= idx + 16'd1;
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (none_out) begin
                        state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sys_array_tile_sched.sv
module tb_sys_array_tile_sched;
    import sys_array_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    node_idx_t   node_last;
    logic        busy, done, err;
    logic [15:0] jobs_issued, jobs_completed;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] t_to_n1 [16];
    logic [15:0] t_aw0 [16];
    logic [15:0] t_aw1 [16];
    logic [15:0] t_al0 [16];
    logic [15:0] t_al1 [16];
    logic [15:0] t_bl0 [16];
    logic [15:0] t_bl1 [16];

    sys_array_tile_sched_if ifc ();

    sys_array_tile_sched #(
        .OUT_SIZE        (100),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .node_last      (node_last),
        .bus            (ifc),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .jobs_issued    (jobs_issued),
        .jobs_completed (jobs_completed)
    );

    always #5 clk = ~clk;

    // Synchronous node-table model: data valid one cycle after the address.
    always @(posedge clk) begin
        ifc.rd_to_n1 <= t_to_n1[ifc.rd_addr[3:0]];
        ifc.rd_a_w0  <= t_aw0[ifc.rd_addr[3:0]];
        ifc.rd_a_w1  <= t_aw1[ifc.rd_addr[3:0]];
        ifc.rd_a_l0  <= t_al0[ifc.rd_addr[3:0]];
        ifc.rd_a_l1  <= t_al1[ifc.rd_addr[3:0]];
        ifc.rd_b_l0  <= t_bl0[ifc.rd_addr[3:0]];
        ifc.rd_b_l1  <= t_bl1[ifc.rd_addr[3:0]];
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_node(input int i, input logic [15:0] to_n1, input logic [15:0] base);
        t_to_n1[i] = to_n1;
        t_aw0[i] = base;
        t_aw1[i] = base + 16'd1;
        t_al0[i] = base + 16'd2;
        t_al1[i] = base + 16'd3;
        t_bl0[i] = base + 16'd4;
        t_bl1[i] = base + 16'd5;
    endtask

    task automatic do_start(input node_idx_t nl);
        node_last = nl;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_done();
        ifc.tile_done = 1'b1;
        @(negedge clk);
        ifc.tile_done = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!ifc.job_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 16'(ifc.job_valid), 16'd1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 16'(done), 16'd1);
    endtask

    initial begin
        int acc;
        for (int i = 0; i < 16; i++) set_node(i, 16'd0, 16'd0);
        reset_n = 1'b0;
        start = 1'b0;
        node_last = '0;
        ifc.job_ready = 1'b0;
        ifc.tile_done = 1'b0;
        #1;
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_err", 16'(err), 16'd0);
        chk("rst_valid", 16'(ifc.job_valid), 16'd0);
        chk("rst_rd_addr", ifc.rd_addr, 16'd0);
        chk("rst_issued", jobs_issued, 16'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Root internal, nodes 1 and 2 leaves
        set_node(0, 16'd1, 16'h100);
        set_node(1, 16'd0, 16'h110);
        set_node(2, 16'd0, 16'h120);
        ifc.job_ready = 1'b1;
        do_start(16'd2);
        chk("t1_busy", 16'(busy), 16'd1);
        wait_valid("t1_valid1");
        chk("t1_node1", ifc.job_node, 16'd1);
        chk("t1_aw0_1", ifc.job_a_w0, 16'h110);
        chk("t1_bl1_1", ifc.job_b_l1, 16'h115);
        @(negedge clk);
        wait_valid("t1_valid2");
        chk("t1_node2", ifc.job_node, 16'd2);
        chk("t1_al1_2", ifc.job_a_l1, 16'h123);
        @(negedge clk);
        chk("t1_issued", jobs_issued, 16'd2);
        repeat (3) @(negedge clk);
        chk("t1_wait_done", 16'(done), 16'd0);
        chk("t1_wait_busy", 16'(busy), 16'd1);
        pulse_done();
        pulse_done();
        wait_done("t1_done");
        chk("t1_busy_end", 16'(busy), 16'd0);
        chk("t1_completed", jobs_completed, 16'd2);
        chk("t1_err", 16'(err), 16'd0);

        // Single-node table, root leaf with bounds 0..9
        t_to_n1[0] = 16'd0;
        t_aw0[0] = 16'd0; t_aw1[0] = 16'd9; t_al0[0] = 16'd0;
        t_al1[0] = 16'd9; t_bl0[0] = 16'd0; t_bl1[0] = 16'd9;
        do_start(16'd0);
        chk("t2_done_clr", 16'(done), 16'd0);
        wait_valid("t2_valid");
        chk("t2_node", ifc.job_node, 16'd0);
        chk("t2_aw1", ifc.job_a_w1, 16'd9);
        repeat (4) @(negedge clk);
        chk("t2_issued", jobs_issued, 16'd1);
        chk("t2_no_more", 16'(ifc.job_valid), 16'd0);
        pulse_done();
        wait_done("t2_done");
        chk("t2_completed", jobs_completed, 16'd1);

        // Back-pressure: job_ready low for 5 cycles
        set_node(0, 16'd0, 16'd1);
        ifc.job_ready = 1'b0;
        do_start(16'd0);
        wait_valid("t3_valid");
        for (int c = 0; c < 5; c++) begin
            chk("t3_hold_valid", 16'(ifc.job_valid), 16'd1);
            chk("t3_hold_node", ifc.job_node, 16'd0);
            chk("t3_hold_aw0", ifc.job_a_w0, 16'd1);
            chk("t3_hold_bl1", ifc.job_b_l1, 16'd6);
            @(negedge clk);
        end
        chk("t3_none_yet", jobs_issued, 16'd0);
        ifc.job_ready = 1'b1;
        @(negedge clk);
        ifc.job_ready = 1'b0;
        chk("t3_dropped", 16'(ifc.job_valid), 16'd0);
        repeat (3) @(negedge clk);
        chk("t3_one_accept", jobs_issued, 16'd1);
        pulse_done();
        wait_done("t3_done");

        // Stray tile_done in IDLE -> sticky err until next start
        pulse_done();
        chk("t4_err_set", 16'(err), 16'd1);
        chk("t4_ignored", jobs_completed, 16'd1);
        repeat (5) @(negedge clk);
        chk("t4_err_sticky", 16'(err), 16'd1);
        ifc.job_ready = 1'b1;
        do_start(16'd0);
        chk("t4_err_clr", 16'(err), 16'd0);
        wait_valid("t4_valid");
        @(negedge clk);
        pulse_done();
        wait_done("t4_done");
        chk("t4_err_end", 16'(err), 16'd0);

        // Six leaves, in-flight limit of 4
        for (int i = 0; i < 6; i++) set_node(i, 16'd0, 16'(16'h200 + 16'(i * 16)));
        do_start(16'd5);
        acc = 0;
        for (int c = 0; c < 30; c++) begin
            if (ifc.job_valid) acc++;
            @(negedge clk);
        end
        chk("t5_accepts", 16'(acc), 16'd4);
        chk("t5_stalled", 16'(ifc.job_valid), 16'd0);
        chk("t5_issued4", jobs_issued, 16'd4);
        pulse_done();
        chk("t5_resume", 16'(ifc.job_valid), 16'd1);
        chk("t5_node4", ifc.job_node, 16'd4);
        chk("t5_aw0_4", ifc.job_a_w0, 16'h240);
        for (int k = 0; k < 5; k++) begin
            repeat (4) @(negedge clk);
            pulse_done();
        end
        wait_done("t5_done");
        chk("t5_issued6", jobs_issued, 16'd6);
        chk("t5_completed6", jobs_completed, 16'd6);
        chk("t5_err", 16'(err), 16'd0);

        // node_last out of range
        do_start(16'd100);
        chk("t6_err", 16'(err), 16'd1);
        wait_done("t6_done");
        chk("t6_issued", jobs_issued, 16'd0);
        chk("t6_busy", 16'(busy), 16'd0);
        chk("t6_valid", 16'(ifc.job_valid), 16'd0);

        // Async reset in the middle of ISSUE
        set_node(0, 16'd1, 16'h300);
        set_node(1, 16'd0, 16'h310);
        set_node(2, 16'd0, 16'h320);
        ifc.job_ready = 1'b1;
        do_start(16'd2);
        wait_valid("t7_valid1");
        @(negedge clk);
        ifc.job_ready = 1'b0;
        wait_valid("t7_valid2");
        chk("t7_node2", ifc.job_node, 16'd2);
        chk("t7_issued1", jobs_issued, 16'd1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("t7_r_valid", 16'(ifc.job_valid), 16'd0);
        chk("t7_r_busy", 16'(busy), 16'd0);
        chk("t7_r_done", 16'(done), 16'd0);
        chk("t7_r_err", 16'(err), 16'd0);
        chk("t7_r_rd_addr", ifc.rd_addr, 16'd0);
        chk("t7_r_node", ifc.job_node, 16'd0);
        chk("t7_r_aw0", ifc.job_a_w0, 16'd0);
        chk("t7_r_issued", jobs_issued, 16'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        set_node(0, 16'd0, 16'h400);
        ifc.job_ready = 1'b1;
        do_start(16'd0);
        wait_valid("t7_clean_valid");
        chk("t7_clean_node", ifc.job_node, 16'd0);
        chk("t7_clean_aw0", ifc.job_a_w0, 16'h400);
        @(negedge clk);
        pulse_done();
        wait_done("t7_clean_done");
        chk("t7_clean_issued", jobs_issued, 16'd1);
        chk("t7_clean_completed", jobs_completed, 16'd1);
        chk("t7_clean_err", 16'(err), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
